// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks.
// Holds the parity mode constants, the transmitter FSM state encoding and a
// constant-evaluable clog2 helper used for port and register widths.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Smallest n with 2**n >= value (clog2(1) == 0).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO shared by the UART transmit and receive paths.
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   push, push_data  write request; ignored while full
//   pop, pop_data    read request; pop_data shows the head word (ignored while empty)
//   full, empty      derived from count
//   count            number of stored words
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int unsigned AW = clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_framed.sv
// Parametrised UART transmitter with an internal transmit FIFO.
// Frames are start(0), DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits(1), each bit CLOCKS_PER_BIT cycles; queued words go out
// back to back with no idle gap.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   in_data       word to send; bits above DATA_BITS-1 are ignored
//   in_valid      in_data valid; accepted when in_ready is high
//   in_ready      FIFO not full
//   uart_data     registered serial line, idles high
//   tx_busy       a frame is on the line
//   fifo_count    queued words, excluding the frame in flight
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 8,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [8:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        uart_data,
  output logic                        tx_busy,
  output logic [clog2(FIFO_DEPTH):0]  fifo_count
);

  if (CLOCKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_framed: CLOCKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_framed: DATA_BITS must be 5..9");
  end
  if (PARITY > PARITY_ODD) begin : g_bad_parity
    $error("uart_tx_framed: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_framed: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned      CW        = clog2(CLOCKS_PER_BIT * 2);
  localparam logic [CW-1:0]    BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0]    STOP_LAST = CW'(STOP_BITS * CLOCKS_PER_BIT - 1);
  localparam logic [3:0]       IDX_LAST  = 4'(DATA_BITS - 1);
  localparam logic             ODD_MODE  = (PARITY == PARITY_ODD);

  tx_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   line_q, line_d;

  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [DATA_BITS-1:0]   pop_word;
  logic                   unused_in_bits;

  // Upper in_data bits are dropped when DATA_BITS < 9.
  assign unused_in_bits = ^in_data;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_data[DATA_BITS-1:0]),
    .pop       (pop),
    .pop_data  (pop_word),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign in_ready  = !full;
  assign uart_data = line_q;
  assign tx_busy   = (state_q != ST_IDLE);

  // The line is registered, so each branch sets line_d to the level the
  // next state must present on its first cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    line_d  = line_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        line_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = pop_word;
          par_d   = (^pop_word) ^ ODD_MODE;
          line_d  = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          line_d  = shreg_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            if (PARITY != PARITY_NONE) begin
              line_d  = par_q;
              state_d = ST_PARITY;
            end else begin
              line_d  = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = shreg_q >> 1;
            line_d  = shreg_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          line_d  = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shreg_d = pop_word;
            par_d   = (^pop_word) ^ ODD_MODE;
            line_d  = 1'b0;
            state_d = ST_START;
          end else begin
            line_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        line_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      line_q  <= line_d;
    end
  end

endmodule
